alu_cmd_sequencer: RTL and testbench

Requester-side controller for the 8-bit combinational alu (5-bit S, Cin, A, B in; Y out). It accepts operation commands over a valid/ready handshake and drives the ALU's S/Cin/A/B from registered state. It samples Y back into an accumulator, optionally repeating the operation up to 8 times, and returns results over a second valid/ready handshake. It replaces hand-written stimulus sequences with a synthesizable driver around the alu instance.

---
 rtl/alu_cmd_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Requester-side controller for an 8-bit combinational ALU.
// It accepts commands over a valid/ready handshake and drives S/Cin/A/B from registered state.
// Y is folded into an accumulator once per iteration.
// When a command asks for it, the accumulator is returned on a valid/ready result port.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_op,
    input  logic             cmd_cin,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_load,
    input  logic             cmd_out,
    output logic [SEL_W-1:0] alu_s,
    output logic             alu_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               cin_q, cin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               cmd_accept;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign cmd_accept = cmd_valid && cmd_ready;

    // The ALU is always driven from registered state, so its inputs hold between commands.
    assign alu_s     = sel_q;
    assign alu_cin   = cin_q;
    assign alu_a     = acc_q;
    assign alu_b     = opnd_q;
    assign res_valid = (state_q == RESP);
    assign res_data  = acc_q;
    assign busy      = (state_q != IDLE);

    // Next-state and register updates: accept in IDLE, iterate in EXEC, hold the result in RESP.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    out_d = cmd_out;
                    if (cmd_load) begin
                        acc_d   = cmd_b;
                        state_d = cmd_out ? RESP : IDLE;
                    end else begin
                        sel_d   = cmd_op;
                        cin_d   = cmd_cin;
                        opnd_d  = cmd_b;
                        cnt_d   = cmd_cnt;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // Y is only trusted here; every other state ignores it.
                acc_d = alu_y;
                if (cnt_q == '0) begin
                    state_d = out_q ? RESP : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU attached.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_op;
    logic       cmd_cin;
    logic [7:0] cmd_b;
    logic [2:0] cmd_cnt;
    logic       cmd_load;
    logic       cmd_out;
    logic [4:0] alu_s;
    logic       alu_cin;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_sequencer #(.WIDTH(8), .SEL_W(5), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
        .cmd_load(cmd_load), .cmd_out(cmd_out),
        .alu_s(alu_s), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // Subset of the ALU function table used by the vectors below.
    always_comb begin
        case (alu_s)
            5'b00000: alu_y = alu_a + 8'(alu_cin);
            5'b00001: alu_y = alu_a + alu_b + 8'(alu_cin);
            5'b01000: alu_y = alu_a << 1;
            default:  alu_y = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command at a negedge; return at the negedge after the accept edge.
    task automatic send(input logic [4:0] op, input logic cin, input logic [7:0] b,
                        input logic [2:0] cnt, input logic load, input logic out);
        bit ok;
        @(negedge clk);
        cmd_op = op; cmd_cin = cin; cmd_b = b; cmd_cnt = cnt;
        cmd_load = load; cmd_out = out; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_wait", ok, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Complete the result handshake from RESP.
    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    logic [7:0] seq_exp [3];
    bit         saw_valid;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cin = 1'b0; cmd_b = '0;
        cmd_cnt = '0; cmd_load = 1'b0; cmd_out = 1'b0; res_ready = 1'b0;

        // Power-on reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_alu", {alu_s, alu_cin, alu_a, alu_b}, 0);
        check("rst_res", {res_valid, res_data}, 0);
        rst = 1'b0;
        #1;
        check("rel_ready", cmd_ready, 1);

        // Asynchronous reset mid-EXEC with non-zero registers clears all outputs at once
        send(5'b00000, 1'b0, 8'h5A, 3'd0, 1'b1, 1'b0);
        send(5'b00001, 1'b1, 8'h11, 3'd7, 1'b0, 1'b1);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_alu", {alu_s, alu_cin, alu_a, alu_b}, {5'b00001, 1'b1, 8'h5A, 8'h11});
        #2 rst = 1'b1;
        #1;
        check("async_alu", {alu_s, alu_cin, alu_a, alu_b}, 0);
        check("async_out", {busy, res_valid, cmd_ready, res_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst", {cmd_ready, busy}, 2'b10);

        // Single-iteration add: AA + 55 = FF
        send(5'b00000, 1'b0, 8'hAA, 3'd0, 1'b1, 1'b0);
        check("load_aa", alu_a, 8'hAA);
        send(5'b00001, 1'b0, 8'h55, 3'd0, 1'b0, 1'b1);
        check("add_exec", {busy, res_valid, alu_a, alu_b}, {2'b10, 8'hAA, 8'h55});
        @(negedge clk);
        check("add_res", {res_valid, res_data}, {1'b1, 8'hFF});
        take_result();
        check("add_done", {res_valid, cmd_ready}, 2'b01);

        // Repeat: three shifts of 0x18
        send(5'b00000, 1'b0, 8'h18, 3'd0, 1'b1, 1'b0);
        send(5'b01000, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
        seq_exp[0] = 8'h18; seq_exp[1] = 8'h30; seq_exp[2] = 8'h60;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("shl_a%0d", i), {busy, res_valid, alu_a}, {2'b10, seq_exp[i]});
            @(negedge clk);
        end
        check("shl_res", {res_valid, res_data}, {1'b1, 8'hC0});

        // Backpressure in RESP with a command waiting
        cmd_op = 5'b00000; cmd_cin = 1'b0; cmd_b = 8'h3C; cmd_cnt = 3'd0;
        cmd_load = 1'b1; cmd_out = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i), {res_valid, cmd_ready, res_data}, {2'b10, 8'hC0});
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_idle", {res_valid, cmd_ready, alu_a}, {2'b01, 8'hC0});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_pending", {res_valid, res_data}, {1'b1, 8'h3C});
        take_result();

        // Wrap: FF + Cin = 00
        send(5'b00000, 1'b0, 8'hFF, 3'd0, 1'b1, 1'b0);
        send(5'b00000, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1);
        check("wrap_exec", {alu_cin, alu_a}, {1'b1, 8'hFF});
        @(negedge clk);
        check("wrap_res", {res_valid, res_data}, {1'b1, 8'h00});
        take_result();

        // Carry-in on every iteration, chained on ACC, no result requested: 10 + 4*(1+1) = 18
        send(5'b00000, 1'b0, 8'h10, 3'd0, 1'b1, 1'b0);
        send(5'b00001, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("cin_chain", {busy, res_valid, alu_a}, {2'b00, 8'h18});

        // Reset in the third EXEC cycle of an 8-iteration shift
        send(5'b00000, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        send(5'b01000, 1'b0, 8'h00, 3'd7, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("abort_a3", {busy, alu_a}, {1'b1, 8'h04});
        #2 rst = 1'b1;
        #1;
        check("abort_now", {busy, res_valid, alu_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
        end
        check("abort_no_res", saw_valid, 0);
        check("abort_idle", {cmd_ready, alu_a}, {1'b1, 8'h00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
